// File: rtl/seg_reveal_seq.sv
// Seven-segment reveal sequencer: latches NUM_DIGITS hex digits and steps
// through single / cumulative / rotate reveal patterns, or shows all digits.
module seg_reveal_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                load,
  input  logic [1:0]                          mode,
  input  logic [4*NUM_DIGITS-1:0]             digits_in,
  output logic [7*NUM_DIGITS-1:0]             seg,
  output logic [$clog2(NUM_DIGITS+2)-1:0]     step,
  output logic                                wrap
);

  localparam int          SW = $clog2(NUM_DIGITS + 2);
  localparam int          CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ND = NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST    = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] LAST_REVEAL = SW'(NUM_DIGITS + 1);
  localparam logic [SW-1:0] LAST_ROT    = SW'(NUM_DIGITS - 1);
  localparam logic [6:0]    BLANK       = 7'h7F;
  localparam logic [7*NUM_DIGITS-1:0] SEG_BLANK =
    (ACTIVE_LOW != 0) ? {NUM_DIGITS{BLANK}} : '0;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_CUMUL  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_STATIC = 2'd3
  } mode_e;

  logic [CW-1:0]           r_cnt;
  logic [SW-1:0]           r_step;
  logic                    r_wrap;
  logic [4*NUM_DIGITS-1:0] r_latch;
  mode_e                   r_mode;
  logic [7*NUM_DIGITS-1:0] r_seg;

  mode_e                   w_mode_in;
  logic                    w_tick;
  logic                    w_restart;
  logic [SW-1:0]           w_last;
  logic [7*NUM_DIGITS-1:0] w_seg_next;
  logic                    w_lit;
  logic [3:0]              w_nib;
  logic [6:0]              w_dseg;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_mode_in = mode_e'(mode);
  assign w_tick    = en && (r_cnt == CNT_LAST);
  assign w_restart = load || (w_mode_in != r_mode);
  assign w_last    = (r_mode == MODE_ROTATE) ? LAST_ROT : LAST_REVEAL;

  // Segment image is built from the registered step/latch/mode, giving the
  // one-cycle lag between a step change and the pins.
  always_comb begin
    w_seg_next = '0;
    w_lit      = 1'b0;
    w_nib      = '0;
    w_dseg     = BLANK;
    for (int unsigned k = 0; k < ND; k++) begin
      w_lit = 1'b0;
      w_nib = r_latch[4*k +: 4];
      case (r_mode)
        MODE_SINGLE: w_lit = (r_step == LAST_REVEAL) || (32'(r_step) + k == ND);
        MODE_CUMUL:  w_lit = (r_step != '0) && (32'(r_step) + k >= ND);
        MODE_ROTATE: begin
          w_lit = 1'b1;
          w_nib = r_latch[4*((k + ND - 32'(r_step)) % ND) +: 4];
        end
        default:     w_lit = 1'b1;
      endcase
      w_dseg = w_lit ? hex_to_seg(w_nib) : BLANK;
      w_seg_next[7*k +: 7] = (ACTIVE_LOW != 0) ? w_dseg : ~w_dseg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_step  <= '0;
      r_wrap  <= 1'b0;
      r_latch <= '0;
      r_mode  <= MODE_SINGLE;
      r_seg   <= SEG_BLANK;
    end else begin
      r_seg  <= w_seg_next;
      r_wrap <= 1'b0;
      if (w_restart) begin
        r_cnt  <= '0;
        r_step <= '0;
        r_mode <= w_mode_in;
        if (load) r_latch <= digits_in;
      end else if (en) begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick && (r_mode != MODE_STATIC)) begin
          if (r_step == w_last) begin
            r_step <= '0;
            r_wrap <= 1'b1;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
      end
    end
  end

  assign seg  = r_seg;
  assign step = r_step;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_seg_reveal_seq.sv
// Bench for seg_reveal_seq: directed test-plan scenarios plus randomized
// traffic checked against an enabled-cycle-count reference model.
module tb_seg_reveal_seq;

  localparam int N    = 4;
  localparam int TICK = 3;
  localparam logic [27:0] BLANK28 = {4{7'h7F}};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] digits = '0;
  logic [27:0] seg, seg_n;
  logic [2:0]  step, step_n;
  logic        wrap, wrap_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: cycles advanced with en=1 since the last restart.
  int          m_ecount;
  logic [1:0]  m_mode;
  logic [15:0] m_latch;
  logic        m_wrap;
  logic [27:0] m_seg;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg_reveal_seq #(.NUM_DIGITS(N), .TICK_DIV(TICK), .ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode),
    .digits_in(digits), .seg(seg), .step(step), .wrap(wrap)
  );

  seg_reveal_seq #(.NUM_DIGITS(N), .TICK_DIV(TICK), .ACTIVE_LOW(0)) u_dut_n (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode),
    .digits_in(digits), .seg(seg_n), .step(step_n), .wrap(wrap_n)
  );

  function automatic int seq_len(input logic [1:0] md);
    return (md == 2'd2) ? N : N + 2;
  endfunction

  function automatic int model_step();
    if (m_mode == 2'd3) return 0;
    return (m_ecount / TICK) % seq_len(m_mode);
  endfunction

  function automatic logic [27:0] display(input logic [1:0] md, input logic [15:0] lat,
                                          input int s);
    logic [15:0] w;
    logic [27:0] r;
    logic [3:0]  nib;
    bit          lit;
    w = lat;
    if (md == 2'd2) w = (lat << (4 * s)) | (lat >> (16 - 4 * s));
    r = '0;
    for (int k = 0; k < N; k++) begin
      nib = w[4*k +: 4];
      case (md)
        2'd0:    lit = (s == N + 1) || (s >= 1 && s <= N && k == N - s);
        2'd1:    lit = (s >= 1) && (k >= N - s);
        default: lit = 1'b1;
      endcase
      r[7*k +: 7] = lit ? tbl[nib] : 7'h7F;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ecount = 0;
    m_mode   = 2'd0;
    m_latch  = '0;
    m_wrap   = 1'b0;
    m_seg    = BLANK28;
  endtask

  task automatic cyc();
    logic [27:0] nxt;
    @(posedge clk);
    nxt = display(m_mode, m_latch, model_step());
    if (load || (mode != m_mode)) begin
      m_ecount = 0;
      m_mode   = mode;
      if (load) m_latch = digits;
      m_wrap = 1'b0;
    end else if (en) begin
      m_ecount++;
      m_wrap = (m_mode != 2'd3) && ((m_ecount % (TICK * seq_len(m_mode))) == 0);
    end else begin
      m_wrap = 1'b0;
    end
    m_seg = nxt;
    #1;
  endtask

  task automatic start_seq(input logic [1:0] md, input logic [15:0] dig);
    en = 1'b1;
    mode = md;
    digits = dig;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_tests++;
    if (seg !== BLANK28) begin n_fail++; $display("FAIL reset_seg got=%h exp=%h", seg, BLANK28); end
    n_tests++;
    if (seg_n !== 28'h0) begin n_fail++; $display("FAIL reset_seg_n got=%h exp=0000000", seg_n); end
    n_tests++;
    if (step !== 3'd0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_step_wrap got step=%0d wrap=%b exp 0/0", step, wrap);
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic run_reveal(input string name, input logic [1:0] md, input int len,
                            input logic [27:0] tab [6]);
    start_seq(md, 16'h5072);
    cyc();
    for (int s = 0; s < len; s++) begin
      if (s > 0) repeat (TICK) cyc();
      n_tests++;
      if (seg !== tab[s] || step !== 3'(s)) begin
        n_fail++;
        $display("FAIL %s_s%0d got seg=%h step=%0d exp seg=%h step=%0d", name, s, seg, step, tab[s], s);
      end
      if (s == 1 && md == 2'd0) begin
        n_tests++;
        if (seg_n[27:21] !== 7'h6D) begin
          n_fail++; $display("FAIL %s_inv_digit5 got=%h exp=6d", name, seg_n[27:21]);
        end
      end
    end
    repeat (TICK - 1) cyc();
    n_tests++;
    if (wrap !== 1'b1 || wrap_n !== 1'b1 || step !== 3'd0) begin
      n_fail++; $display("FAIL %s_wrap got wrap=%b step=%0d exp wrap=1 step=0", name, wrap, step);
    end
    cyc();
    n_tests++;
    if (wrap !== 1'b0 || seg !== tab[0]) begin
      n_fail++; $display("FAIL %s_after_wrap got wrap=%b seg=%h exp wrap=0 seg=%h", name, wrap, seg, tab[0]);
    end
  endtask

  task automatic test_single();
    logic [27:0] tab [6];
    tab[0] = BLANK28;
    tab[1] = {7'h12, 7'h7F, 7'h7F, 7'h7F};
    tab[2] = {7'h7F, 7'h40, 7'h7F, 7'h7F};
    tab[3] = {7'h7F, 7'h7F, 7'h78, 7'h7F};
    tab[4] = {7'h7F, 7'h7F, 7'h7F, 7'h24};
    tab[5] = {7'h12, 7'h40, 7'h78, 7'h24};
    run_reveal("single", 2'd0, 6, tab);
  endtask

  task automatic test_cumulative();
    logic [27:0] tab [6];
    tab[0] = BLANK28;
    tab[1] = {7'h12, 7'h7F, 7'h7F, 7'h7F};
    tab[2] = {7'h12, 7'h40, 7'h7F, 7'h7F};
    tab[3] = {7'h12, 7'h40, 7'h78, 7'h7F};
    tab[4] = {7'h12, 7'h40, 7'h78, 7'h24};
    tab[5] = {7'h12, 7'h40, 7'h78, 7'h24};
    run_reveal("cumul", 2'd1, 6, tab);
  endtask

  task automatic test_rotate();
    logic [27:0] tab [6];
    tab[0] = {7'h12, 7'h40, 7'h78, 7'h24};
    tab[1] = {7'h40, 7'h78, 7'h24, 7'h12};
    tab[2] = {7'h78, 7'h24, 7'h12, 7'h40};
    tab[3] = {7'h24, 7'h12, 7'h40, 7'h78};
    tab[4] = '0;
    tab[5] = '0;
    run_reveal("rotate", 2'd2, 4, tab);
  endtask

  task automatic test_freeze();
    logic [27:0] s2;
    s2 = {7'h7F, 7'h40, 7'h7F, 7'h7F};
    start_seq(2'd0, 16'h5072);
    repeat (7) cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_tests++;
      if (step !== 3'd2 || seg !== s2 || wrap !== 1'b0) begin
        n_fail++; $display("FAIL freeze_hold_%0d got step=%0d seg=%h exp step=2 seg=%h", i, step, seg, s2);
      end
    end
    en = 1'b1;
    cyc();
    n_tests++;
    if (step !== 3'd2) begin n_fail++; $display("FAIL freeze_resume1 got step=%0d exp 2", step); end
    cyc();
    n_tests++;
    if (step !== 3'd3) begin n_fail++; $display("FAIL freeze_resume2 got step=%0d exp 3", step); end
  endtask

  task automatic test_load_tick();
    logic [15:0] nd;
    logic [27:0] exp_all;
    nd = 16'($urandom);
    start_seq(2'd0, 16'h5072);
    repeat (14) cyc();
    n_tests++;
    if (step !== 3'd4) begin n_fail++; $display("FAIL loadtick_pre got step=%0d exp 4", step); end
    digits = nd;
    load = 1'b1;
    cyc();
    load = 1'b0;
    n_tests++;
    if (step !== 3'd0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL loadtick_restart got step=%0d wrap=%b exp 0/0", step, wrap);
    end
    cyc();
    n_tests++;
    if (seg !== BLANK28) begin n_fail++; $display("FAIL loadtick_blank got=%h exp=%h", seg, BLANK28); end
    cyc();
    cyc();
    n_tests++;
    if (step !== 3'd1) begin n_fail++; $display("FAIL loadtick_prescaler got step=%0d exp 1", step); end
    mode = 2'd3;
    cyc();
    n_tests++;
    if (step !== 3'd0) begin n_fail++; $display("FAIL static_step got=%0d exp 0", step); end
    cyc();
    exp_all = display(2'd3, nd, 0);
    n_tests++;
    if (seg !== exp_all) begin n_fail++; $display("FAIL static_seg got=%h exp=%h", seg, exp_all); end
    repeat (20) cyc();
    n_tests++;
    if (step !== 3'd0 || wrap !== 1'b0 || seg !== exp_all) begin
      n_fail++; $display("FAIL static_hold got step=%0d wrap=%b seg=%h exp 0/0/%h", step, wrap, seg, exp_all);
    end
  endtask

  task automatic test_async_reset();
    start_seq(2'd0, 16'h5072);
    repeat (15) cyc();
    n_tests++;
    if (step !== 3'd5) begin n_fail++; $display("FAIL areset_pre got step=%0d exp 5", step); end
    cyc();
    #3;
    rst = 1'b0;
    #1;
    n_tests++;
    if (seg !== BLANK28 || step !== 3'd0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL areset_now got seg=%h step=%0d wrap=%b exp %h/0/0", seg, step, wrap, BLANK28);
    end
    n_tests++;
    if (seg_n !== 28'h0) begin n_fail++; $display("FAIL areset_inv got=%h exp=0000000", seg_n); end
    model_reset();
    mode = 2'd0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    cyc();
    n_tests++;
    if (seg !== BLANK28 || step !== 3'd0) begin
      n_fail++; $display("FAIL areset_release got seg=%h step=%0d exp %h/0", seg, step, BLANK28);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      digits = 16'($urandom);
      cyc();
      n_tests++;
      if (seg !== m_seg || seg_n !== ~m_seg) begin
        n_fail++; $display("FAIL rand_seg cyc=%0d got=%h/%h exp=%h", i, seg, seg_n, m_seg);
      end
      n_tests++;
      if (step !== 3'(model_step()) || wrap !== m_wrap) begin
        n_fail++; $display("FAIL rand_step cyc=%0d got step=%0d wrap=%b exp step=%0d wrap=%b",
                           i, step, wrap, model_step(), m_wrap);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_cumulative();
    test_rotate();
    test_freeze();
    test_load_tick();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
